framebuffer_arbiter: RTL and testbench
======================================

# framebuffer_arbiter

Arbitrates one single-port frame buffer RAM between the LED-matrix scan engine and a host writer. The scan engine reads pixel pairs (upper and lower half-panel pixels) and has priority. The host gets a guaranteed slot after a bounded number of consecutive display grants. With double buffering compiled in, the block also owns front/back page selection and swaps pages only at frame boundaries, so the panel never shows a half-written image.

## Interface
- `ADDR_W`, default 10: pixel-pair address width (64 columns × 16 row addresses).
- `DATA_W`, default 48: one pixel pair, 2 × 24-bit RGB.
- `STARVE_MAX`, default 4: maximum consecutive display grants while the host is waiting; range 1–15.
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `disp_req`, in, 1: scan engine access request; held until `disp_ack`.
- `disp_addr`, in, ADDR_W: scan read address.
- `disp_ack`, out, 1: one-cycle grant for the display request.
- `disp_data`, out, DATA_W: read data, driven directly from `ram_rdata`.
- `disp_valid`, out, 1: `disp_data` is valid this cycle.
- `disp_frame_done`, in, 1: one-cycle pulse when the scan engine finishes a frame.
- `host_req`, in, 1: host access request; held until `host_ack`.
- `host_we`, in, 1: 1 = write, 0 = read.
- `host_addr`, in, ADDR_W: host address.
- `host_wdata`, in, DATA_W: host write data.
- `host_ack`, out, 1: one-cycle grant for the host request.
- `host_rdata`, out, DATA_W: host read data, driven directly from `ram_rdata`.
- `host_rvalid`, out, 1: `host_rdata` is valid this cycle.
- `host_swap_req`, in, 1: pulse requesting a page swap.
- `swap_pending`, out, 1: a swap is armed and waiting for a frame boundary.
- `swap_done`, out, 1: one-cycle pulse when the swap takes effect.
- `front_sel`, out, 1: page currently displayed.
- `ram_en`, out, 1: RAM access enable.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, ADDR_W+1: RAM address; the MSB is the page bit.
- `ram_wdata`, out, DATA_W: RAM write data.
- `ram_rdata`, in, DATA_W: RAM read data; RAM read latency is 1 cycle.

## Operation
- **Grant decision**
  - Made every cycle from registered state and the current requests.
  - At most one grant per cycle.
  - Back-to-back grants are allowed; a request held high after its ack is treated as a new access.
- **Priority**
  - Display wins by default.
  - Host wins if only the host requests, or if `starve_ctr == STARVE_MAX`.
- **Starvation counter (`starve_ctr`, 4 bits)**
  - Increments on a display grant while `host_req` = 1.
  - Clears on any host grant, or in any cycle where `host_req` = 0.
  - Saturates at STARVE_MAX.
- **Granted access**
  - All of `ram_en`, `ram_we`, `ram_addr`, `ram_wdata` and the ack are registered and asserted together.
  - `ram_we` = `host_we` for a host grant, 0 for a display grant.
- **Page selection**
  - Display accesses use `ram_addr[ADDR_W]` = `front_sel`.
  - Host accesses use `~front_sel`.
- **Read return**
  - `disp_valid` / `host_rvalid` is asserted the cycle after a granted read.
  - No valid is returned for host writes.
- **Swap FSM**
  - States are IDLE and ARMED.
  - IDLE → ARMED on `host_swap_req`; `swap_pending` = 1 while ARMED.
  - ARMED → IDLE on `disp_frame_done`: `front_sel` toggles and `swap_done` pulses in the same registered update.
  - `host_swap_req` while ARMED is ignored.
  - `host_swap_req` and `disp_frame_done` in the same cycle from IDLE: the block arms only, and the swap waits for the next `disp_frame_done`.
- **Reset**
  - All outputs are 0 during and after reset: acks, valids, `ram_*`, `front_sel`, `swap_pending`, `swap_done`.
  - `starve_ctr` clears and the FSM enters IDLE.
  - An in-flight read's valid is dropped.

## Timing
- Request sampled high in cycle N, no competing winner → ack and RAM strobe in cycle N+1 → read valid in cycle N+2.
- A requester deasserting `req` before its ack gets no access; no grant is made for a withdrawn request.
- Display throughput: 1 access per cycle when the host is idle.
- Worst-case host wait under continuous display load: STARVE_MAX + 1 cycles from request to ack.
- Swap latency: from the first `disp_frame_done` strictly after the request, plus 1 cycle to `front_sel` change.

## Configuration
- `FRAMEBUFFER_DOUBLE_BUFFER_EN` **defined**: two pages and the swap FSM, as described above.
- **Undefined**:
  - Single page: `ram_addr[ADDR_W]` = 0 for all accesses; `front_sel` = 0.
  - Swap FSM removed: `host_swap_req` and `disp_frame_done` are ignored; `swap_pending` and `swap_done` are tied to 0.
  - Port list is unchanged.

## Test plan
- Display-only reads at addresses 0..63 with `disp_req` held → 64 consecutive acks, `disp_valid` one cycle after each, `ram_addr` = {0, addr}.
- Both requesting continuously, STARVE_MAX = 4 → grant pattern D,D,D,D,H repeating; the host waits exactly 5 cycles for each ack.
- Host writes 48'hABCDEF123456 to address 5, swap, then display read of address 5 → `disp_data` = 48'hABCDEF123456 after `swap_done`.
- `host_swap_req` coincident with `disp_frame_done` → `swap_pending` = 1, `front_sel` unchanged; next `disp_frame_done` → `front_sel` = 1, `swap_done` = 1 for one cycle.
- `rst` asserted low the cycle after a display read grant → `disp_valid` never asserts, all outputs 0, first grant after release behaves as from reset.
- Macro undefined: `host_swap_req` then `disp_frame_done` → `front_sel` stays 0 and host and display share page 0.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// Display/host arbiter for a single-port frame buffer RAM, display has priority.
// Define FRAMEBUFFER_DOUBLE_BUFFER_EN for front/back pages with frame-synced swap.
module framebuffer_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 48,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              disp_frame_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_sel,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [3:0] starve_ctr;
  logic       host_win;
  logic       disp_win;
  logic       disp_page;
  logic       host_page;

  assign host_win = host_req &&
                    (!disp_req || starve_ctr == SMAX);
  assign disp_win = disp_req && !host_win;

  assign disp_page  = front_sel;
  assign disp_data  = ram_rdata;
  assign host_rdata = ram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_ctr  <= '0;
      disp_ack    <= 1'b0;
      host_ack    <= 1'b0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      disp_valid  <= 1'b0;
      host_rvalid <= 1'b0;
    end else begin
      disp_ack    <= disp_win;
      host_ack    <= host_win;
      ram_en      <= disp_win | host_win;
      ram_we      <= host_win & host_we;
      ram_wdata   <= host_win ? host_wdata : '0;
      disp_valid  <= disp_ack;
      host_rvalid <= host_ack & ~ram_we;
      unique case (1'b1)
        host_win: ram_addr <= {host_page, host_addr};
        disp_win: ram_addr <= {disp_page, disp_addr};
        default:  ram_addr <= '0;
      endcase
      if (host_win || !host_req)
        starve_ctr <= '0;
      else if (disp_win && starve_ctr != SMAX)
        starve_ctr <= starve_ctr + 4'd1;
    end
  end

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  typedef enum logic {IDLE, ARMED} swap_st_t;
  swap_st_t st;

  assign host_page = ~front_sel;

  // A swap armed in a frame_done cycle waits for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st           <= IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      unique case (st)
        IDLE: if (host_swap_req) begin
          st           <= ARMED;
          swap_pending <= 1'b1;
        end
        ARMED: if (disp_frame_done) begin
          st           <= IDLE;
          swap_pending <= 1'b0;
          front_sel    <= ~front_sel;
          swap_done    <= 1'b1;
        end
      endcase
    end
  end
`else
  logic unused_swap;

  assign unused_swap  = host_swap_req ^ disp_frame_done;
  assign host_page    = 1'b0;
  assign front_sel    = 1'b0;
  assign swap_pending = 1'b0;
  assign swap_done    = 1'b0;
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed steps plus random traffic
// checked against a cycle-level reference model and a RAM model.
module tb_framebuffer_arbiter;

  localparam int AW = 10;
  localparam int DW = 48;
  localparam int SM = 4;
  localparam int NW = 2 ** (AW + 1);
`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req, disp_ack, disp_valid;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_frame_done;
  logic          host_req, host_we, host_ack, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_swap_req, swap_pending, swap_done, front_sel;
  logic          ram_en, ram_we;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  framebuffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_frame_done(disp_frame_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_swap_req(host_swap_req), .swap_pending(swap_pending),
    .swap_done(swap_done), .front_sel(front_sel),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] ram_mem [NW];
  logic [DW-1:0] ref_mem [NW];
  bit            pend_v;
  logic [AW:0]   pend_a;

  int            streak;
  bit            armed, front;
  bit            pgd, pgh, pwe;
  logic [DW-1:0] pdata;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    streak = 0;
    armed  = 1'b0;
    front  = 1'b0;
    pgd    = 1'b0;
    pgh    = 1'b0;
    pwe    = 1'b0;
    pend_v = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".disp_ack"}, disp_ack, 0);
    chk({tag, ".host_ack"}, host_ack, 0);
    chk({tag, ".disp_valid"}, disp_valid, 0);
    chk({tag, ".host_rvalid"}, host_rvalid, 0);
    chk({tag, ".ram_en"}, ram_en, 0);
    chk({tag, ".ram_we"}, ram_we, 0);
    chk({tag, ".ram_addr"}, ram_addr, 0);
    chk({tag, ".ram_wdata"}, ram_wdata, 0);
    chk({tag, ".front_sel"}, front_sel, 0);
    chk({tag, ".swap_pending"}, swap_pending, 0);
    chk({tag, ".swap_done"}, swap_done, 0);
  endtask

  // One clock: predict from current inputs, advance, compare, serve RAM.
  task automatic step();
    bit gh, gd, hp, dp, hwe, sdone;
    logic [AW:0]   ea;
    logic [DW-1:0] rd;
    hwe = host_we;
    gh  = host_req && (!disp_req || streak >= SM);
    gd  = disp_req && !gh;
    dp  = DB ? front : 1'b0;
    hp  = DB ? !front : 1'b0;
    ea  = gh ? {hp, host_addr} : {dp, disp_addr};
    rd  = ref_mem[ea];
    if (gh && hwe) ref_mem[ea] = host_wdata;
    if (gh || !host_req) streak = 0;
    else if (gd && streak < SM) streak++;
    sdone = 1'b0;
    if (DB) begin
      if (!armed) armed = host_swap_req;
      else if (disp_frame_done) begin
        armed = 1'b0;
        front = !front;
        sdone = 1'b1;
      end
    end
    @(posedge clk);
    if (pend_v) ram_rdata = ram_mem[pend_a];
    #1;
    chk("disp_ack", disp_ack, gd);
    chk("host_ack", host_ack, gh);
    chk("ram_en", ram_en, gd | gh);
    chk("ram_we", ram_we, gh & hwe);
    if (gd | gh) chk("ram_addr", ram_addr, ea);
    if (gh & hwe) chk("ram_wdata", ram_wdata, host_wdata);
    chk("disp_valid", disp_valid, pgd);
    if (pgd) chk("disp_data", disp_data, pdata);
    chk("host_rvalid", host_rvalid, pgh & !pwe);
    if (pgh & !pwe) chk("host_rdata", host_rdata, pdata);
    chk("front_sel", front_sel, front);
    chk("swap_pending", swap_pending, armed);
    chk("swap_done", swap_done, sdone);
    pgd   = gd;
    pgh   = gh;
    pwe   = hwe;
    pdata = rd;
    pend_v = 1'b0;
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] = ram_wdata;
      else begin
        pend_v = 1'b1;
        pend_a = ram_addr;
      end
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, nh, last;
    rst = 1'b0;
    disp_req = 0; disp_addr = '0; disp_frame_done = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_swap_req = 0; ram_rdata = '0;
    for (int i = 0; i < NW; i++) begin
      ram_mem[i] = {16'(i), 32'(i * 32'h9E3779B1)};
      ref_mem[i] = ram_mem[i];
    end
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    acks = 0;
    disp_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      disp_addr = AW'(i);
      step();
      if (disp_ack) acks++;
    end
    disp_req = 1'b0;
    step();
    chk("disp_run_acks", acks, 64);

    nh = 0;
    last = -1;
    disp_req = 1'b1;
    host_req = 1'b1;
    host_addr = AW'(9);
    for (int c = 0; c < 25; c++) begin
      disp_addr = AW'(c);
      step();
      if (host_ack) begin
        chk("host_wait", c - last, last < 0 ? 5 : 5);
        last = c;
        nh++;
      end
    end
    chk("host_acks", nh, 5);
    disp_req = 1'b0;
    host_req = 1'b0;
    step();
    step();

    host_swap_req = 1'b1;
    disp_frame_done = 1'b1;
    step();
    host_swap_req = 1'b0;
    disp_frame_done = 1'b0;
    chk("coinc_pending", swap_pending, DB);
    chk("coinc_front", front_sel, 0);
    step();
    disp_frame_done = 1'b1;
    step();
    disp_frame_done = 1'b0;
    chk("coinc_swap_front", front_sel, DB);
    chk("coinc_swap_done", swap_done, DB);
    step();
    chk("swap_done_pulse", swap_done, 0);

    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = AW'(5);
    host_wdata = 48'hABCDEF123456;
    step();
    host_req = 1'b0;
    host_we = 1'b0;
    step();
    host_swap_req = 1'b1;
    step();
    host_swap_req = 1'b0;
    disp_frame_done = 1'b1;
    step();
    disp_frame_done = 1'b0;
    chk("wr_swap_done", swap_done, DB);
    disp_req = 1'b1;
    disp_addr = AW'(5);
    step();
    disp_req = 1'b0;
    step();
    chk("wr_swap_valid", disp_valid, 1);
    chk("wr_swap_data", disp_data, 48'hABCDEF123456);

    disp_req = 1'b1;
    disp_addr = AW'(7);
    step();
    chk("pre_rst_ack", disp_ack, 1);
    disp_req = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("in_rst");
    rst = 1'b1;
    reset_model();
    step();
    chk("post_rst_valid", disp_valid, 0);
    disp_req = 1'b1;
    disp_addr = AW'(3);
    step();
    chk("post_rst_ack", disp_ack, 1);
    chk("post_rst_addr", ram_addr, 11'd3);
    disp_req = 1'b0;
    step();

    for (int n = 0; n < 400; n++) begin
      if (!disp_req || disp_ack) begin
        disp_req  = ($urandom % 4) != 0;
        disp_addr = AW'($urandom);
      end else if ($urandom % 8 == 0) disp_req = 1'b0;
      if (!host_req || host_ack) begin
        host_req   = ($urandom % 2) != 0;
        host_we    = ($urandom % 2) != 0;
        host_addr  = AW'($urandom);
        host_wdata = 48'({$urandom, $urandom});
      end else if ($urandom % 8 == 0) host_req = 1'b0;
      host_swap_req   = ($urandom % 16) == 0;
      disp_frame_done = ($urandom % 12) == 0;
      step();
    end
    disp_req = 1'b0;
    host_req = 1'b0;
    host_swap_req = 1'b0;
    disp_frame_done = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
